// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller.
// Contents: opcode constants, funct_3 access encodings, FSM state type and
// small decode helpers used by the controller top.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  // Access size/sign encodings carried in funct_3.
  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } f3_e;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StResp,
    StFault
  } lsu_state_e;

  // Stores only support signed-size encodings; loads also allow BU/HU.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct_3[1:0] carries the size: 0 byte, 1 half, 2 word.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic ok;
    case (f3[1:0])
      2'd0:    ok = 1'b1;
      2'd1:    ok = (addr_lo[0] == 1'b0);
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Single-port data-memory bus between the LSU controller and memory.
// master: controller side (drives request, write enable, address, byte
//         enables and write data; receives grant, rvalid and read data).
// slave:  memory side.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the LSU.
// Request side: funct_3/addr_lo/store_data -> byte enables and lane-aligned
//               write data (disabled lanes driven to zero).
// Load side:    ld_funct_3/ld_addr_lo/rdata -> sign/zero-extended result.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct_3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct_3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be = 4'b1111;
    case (funct_3[1:0])
      2'd0:    be = 4'b0001 << addr_lo;
      2'd1:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
  end

  // Lanes outside the access carry zero so the bus never sees stale rs2 bytes.
  always_comb begin
    shifted = store_data << {addr_lo, 3'b000};
    wdata   = '0;
    for (int i = 0; i < 4; i++) begin
      wdata[8*i +: 8] = be[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    ld_byte = 8'h00;
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rdata_ext = '0;
    case (f3_e'(ld_funct_3))
      F3_B:    rdata_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    rdata_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {24'h000000, ld_byte};
      F3_HU:   rdata_ext = {16'h0000, ld_half};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and the data-memory bus.
// Core side:  req_valid/opcode/funct_3/addr/store_data in; req_ready, stall,
//             done, load_data, misaligned, access_fault out.
// Memory side: bus (lsu_mem_ctrl_if.master) request/grant/rvalid handshake.
// All outputs except stall are registered; stall also covers the accept cycle.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct_3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              req_ready,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              access_fault,
  lsu_mem_ctrl_if.master    bus
);

  localparam int unsigned CntW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  lsu_state_e        state_q;
  logic              req_ready_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic [31:0]       load_data_q;
  logic              misaligned_q;
  logic              access_fault_q;
  logic              is_store_q;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [CntW-1:0]   cnt_q;

  logic        is_load;
  logic        is_store;
  logic        accept;
  logic        f3_ok;
  logic        align_ok;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata_ext;

  lsu_lane_align u_lane_align (
    .funct_3    (funct_3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .be         (be),
    .wdata      (wdata),
    .ld_funct_3 (f3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (bus.mem_rdata),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    is_load     = (opcode == OP_LOAD);
    is_store    = (opcode == OP_STORE);
    accept      = req_valid && req_ready_q && (is_load || is_store);
    f3_ok       = f3_legal(is_store, funct_3);
    align_ok    = addr_aligned(funct_3, addr[1:0]);
    // A zero TIMEOUT never matches, so the wait is unbounded.
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_ready_q    <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= '0;
      mem_wdata_q    <= '0;
      done_q         <= 1'b0;
      load_data_q    <= '0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      is_store_q     <= 1'b0;
      f3_q           <= '0;
      addr_lo_q      <= '0;
      cnt_q          <= '0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            is_store_q  <= is_store;
            f3_q        <= funct_3;
            addr_lo_q   <= addr[1:0];
            if (!f3_ok) begin
              access_fault_q <= 1'b1;
              state_q        <= StFault;
            end else if (!align_ok) begin
              misaligned_q <= 1'b1;
              state_q      <= StFault;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be;
              mem_wdata_q <= wdata;
              cnt_q       <= '0;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          // rvalid alongside gnt is ignored; data comes in a later cycle.
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StWait;
          end else if (timeout_hit) begin
            mem_req_q      <= 1'b0;
            access_fault_q <= 1'b1;
            state_q        <= StFault;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWait: begin
          if (bus.mem_rvalid) begin
            done_q      <= 1'b1;
            load_data_q <= is_store_q ? 32'h0 : rdata_ext;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            access_fault_q <= 1'b1;
            state_q        <= StFault;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          load_data_q <= '0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        StFault: begin
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          mem_req_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign stall         = !req_ready_q || accept;
  assign done          = done_q;
  assign load_data     = load_data_q;
  assign misaligned    = misaligned_q;
  assign access_fault  = access_fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (TIMEOUT = 4).
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct_3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        req_ready;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        access_fault;

  int n_chk;
  int n_bad;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_mem_ctrl #(
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .opcode       (opcode),
    .funct_3      (funct_3),
    .addr         (addr),
    .store_data   (store_data),
    .req_ready    (req_ready),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; caller is at posedge+1.
  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
    req_valid  = 1'b1;
    opcode     = op;
    funct_3    = f3;
    addr       = a;
    store_data = sd;
    #1;
  endtask

  // Full legal access with immediate grant and rvalid.
  task automatic run_access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                            input logic exp_we, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    present(op, f3, a, sd);
    check({tag, "_stall_acc"}, {31'b0, stall}, 32'd1);
    step();
    req_valid = 1'b0;
    check({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
    check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, "_be"}, {28'b0, bus.mem_be}, {28'b0, exp_be});
    check({tag, "_we"}, {31'b0, bus.mem_we}, {31'b0, exp_we});
    if (exp_we) check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'b0, bus.mem_req}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    step();
    bus.mem_rvalid = 1'b0;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_ld"}, load_data, exp_ld);
    check({tag, "_rdy_resp"}, {31'b0, req_ready}, 32'd0);
    step();
    check({tag, "_done_off"}, {31'b0, done}, 32'd0);
    check({tag, "_rdy_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    n_chk          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    opcode         = '0;
    funct_3        = '0;
    addr           = '0;
    store_data     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    step();

    run_access("lb",  OP_LOAD, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 4'b1000, 32'h0,
               32'hFFFF_FF80);
    run_access("lhu", OP_LOAD, 3'd5, 32'h202, 32'h0, 32'hBEEF_0000, 1'b0, 4'b1100, 32'h0,
               32'h0000_BEEF);
    run_access("lh",  OP_LOAD, 3'd1, 32'h202, 32'h0, 32'hBEEF_0000, 1'b0, 4'b1100, 32'h0,
               32'hFFFF_BEEF);
    run_access("lbu", OP_LOAD, 3'd4, 32'h102, 32'h0, 32'h80FF_1234, 1'b0, 4'b0100, 32'h0,
               32'h0000_00FF);
    run_access("sb",  OP_STORE, 3'd0, 32'h301, 32'h1234_56AB, 32'h0, 1'b1, 4'b0010,
               32'h0000_AB00, 32'h0);
    run_access("sh",  OP_STORE, 3'd1, 32'h302, 32'h0000_CAFE, 32'h0, 1'b1, 4'b1100,
               32'hCAFE_0000, 32'h0);
    run_access("sw",  OP_STORE, 3'd2, 32'h404, 32'hA5A5_1234, 32'h0, 1'b1, 4'b1111,
               32'hA5A5_1234, 32'h0);

    // Non-memory opcode is ignored; stray rvalid in IDLE is ignored.
    present(7'h33, 3'd2, 32'h0, 32'h0);
    check("ign_stall", {31'b0, stall}, 32'd0);
    bus.mem_rvalid = 1'b1;
    step();
    req_valid      = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("ign_ready", {31'b0, req_ready}, 32'd1);
    check("ign_req", {31'b0, bus.mem_req}, 32'd0);
    check("ign_done", {31'b0, done}, 32'd0);

    // Misaligned word load.
    present(OP_LOAD, 3'd2, 32'h402, 32'h0);
    step();
    req_valid = 1'b0;
    check("mis_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_fault", {31'b0, access_fault}, 32'd0);
    check("mis_req", {31'b0, bus.mem_req}, 32'd0);
    check("mis_stall", {31'b0, stall}, 32'd1);
    step();
    check("mis_off", {31'b0, misaligned}, 32'd0);
    check("mis_ready", {31'b0, req_ready}, 32'd1);
    check("mis_req2", {31'b0, bus.mem_req}, 32'd0);

    // Illegal funct_3.
    present(OP_LOAD, 3'd3, 32'h0, 32'h0);
    step();
    req_valid = 1'b0;
    check("f3_fault", {31'b0, access_fault}, 32'd1);
    check("f3_mis", {31'b0, misaligned}, 32'd0);
    check("f3_req", {31'b0, bus.mem_req}, 32'd0);
    step();
    check("f3_off", {31'b0, access_fault}, 32'd0);
    check("f3_ready", {31'b0, req_ready}, 32'd1);

    // Grant never comes: mem_req for exactly 4 cycles, then fault.
    present(OP_LOAD, 3'd2, 32'h0, 32'h0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), {31'b0, bus.mem_req}, 32'd1);
      check($sformatf("to_nf%0d", i), {31'b0, access_fault}, 32'd0);
      step();
    end
    check("to_fault", {31'b0, access_fault}, 32'd1);
    check("to_req_off", {31'b0, bus.mem_req}, 32'd0);
    step();
    check("to_off", {31'b0, access_fault}, 32'd0);
    check("to_ready", {31'b0, req_ready}, 32'd1);

    // Reset while waiting for rvalid.
    present(OP_LOAD, 3'd2, 32'h8, 32'h0);
    step();
    req_valid   = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("rw_in_wait", {31'b0, stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_ready", {31'b0, req_ready}, 32'd1);
    check("rw_stall", {31'b0, stall}, 32'd0);
    check("rw_req", {31'b0, bus.mem_req}, 32'd0);
    check("rw_addr", bus.mem_addr, 32'h0);
    check("rw_be", {28'b0, bus.mem_be}, 32'h0);
    #2 rst_n = 1'b1;
    step();
    run_access("lw0", OP_LOAD, 3'd2, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,
               32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequences every load/store between the execute stage and the single-port data-memory bus.
- Functions:
  - accepts one LOAD/STORE request (opcode 7'h03 / 7'h23, funct_3) from the core;
  - checks alignment;
  - generates the word-aligned address, byte enables and lane-shifted write data;
  - runs the request/grant/rvalid handshake with memory;
  - returns the sign/zero-extended load result;
  - stalls the core while the access is in flight.

Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT, 255, max cycles waiting for grant or rvalid before an access fault; 0 disables the timeout

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory instruction
- opcode  in  7  instruction opcode
- funct_3  in  3  access size/sign
- addr  in  ADDR_W  effective byte address
- store_data  in  32  rs2 value, unshifted
- req_ready  out  1  controller idle, request accepted this cycle
- stall  out  1  hold the pipeline
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  32  raw read word
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid with done
- misaligned  out  1  one-cycle exception pulse, no bus access issued
- access_fault  out  1  one-cycle timeout or illegal funct_3 pulse

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE;
  - all outputs 0 except req_ready = 1;
  - internal registers cleared.
- Acceptance:
  - A request is accepted when req_valid && req_ready && opcode ∈ {03, 23}.
  - Other opcodes are ignored and stay in IDLE.
  - On acceptance, latch opcode, funct_3, addr[1:0], the word address and the shifted store data.
- Legal funct_3 values:
  - loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU;
  - stores: 0 SB, 1 SH, 2 SW.
  - Any other value: go to FAULT.
- Alignment:
  - H requires addr[0] = 0; W requires addr[1:0] = 0.
  - Violation: go to FAULT with misaligned.
- Byte enables:
  - B: 4'b0001 << addr[1:0];
  - H: 4'b0011 << addr[1:0];
  - W: 4'b1111.
- Store data: store_data << (8 × addr[1:0]).
- Loads use the same mem_be.
- FSM states: IDLE, REQ, WAIT, RESP, FAULT.
  - IDLE: req_ready = 1, stall = 0.
    - Legal accept → REQ.
    - Illegal accept → FAULT.
  - REQ: mem_req = 1; mem_addr, mem_be, mem_we and mem_wdata are stable.
    - mem_gnt → WAIT; mem_req drops the next cycle.
  - WAIT: wait for mem_rvalid.
    - On mem_rvalid, register the extended data → RESP.
  - RESP: done = 1 and load_data valid for one cycle → IDLE.
  - FAULT: misaligned or access_fault = 1 for one cycle → IDLE. No bus activity.
- stall = 1 in every state except IDLE. Stall is also 1 combinationally in the accept cycle.
- Load extraction: byte/half selected by latched addr[1:0].
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Stores: load_data = 0.
- Latency, with grant and rvalid each arriving on their first eligible cycle: accept at cycle 0, done at cycle 3.
- Timeout:
  - Counter reloads on entry to REQ and again on entry to WAIT.
  - Reaching TIMEOUT in either state → FAULT with access_fault; mem_req drops.
- Simultaneous gnt and rvalid in REQ: treated as gnt only. The memory guarantees rvalid arrives ≥1 cycle after gnt.
- Stray mem_rvalid in IDLE/REQ: ignored.
- Reset mid-access: immediate return to IDLE. The outstanding bus transaction is abandoned; mem_req deasserts asynchronously.

Decomposition:
- Shared package lsu_pkg:
  - opcode constants OP_LOAD = 7'h03, OP_STORE = 7'h23;
  - funct_3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state typedef.
- Sub-module lsu_lane_align (combinational): computes be/wdata/extended rdata from funct_3, addr[1:0] and data. The FSM lives in the top.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_1234 (gnt and rvalid immediate) → mem_addr 0x100, mem_be 4'b1000, done at cycle 3, load_data 0xFFFF_FF80.
- LHU at 0x202, rdata 0xBEEF_0000 → mem_be 4'b1100, load_data 0x0000_BEEF; same with LH → 0xFFFF_BEEF.
- SB at 0x301, store_data 0x1234_56AB → mem_we 1, mem_be 4'b0010, mem_wdata 0x0000_AB00; done after rvalid; req_ready low until done+1.
- LW at 0x402 → misaligned pulse 1 cycle after accept, mem_req never asserts, back to IDLE. funct_3 = 3 → access_fault pulse, no bus activity.
- TIMEOUT = 4, mem_gnt held low → mem_req high 4 cycles, then access_fault pulse, mem_req 0, IDLE.
- rst_n asserted in WAIT → all outputs reset immediately, req_ready = 1; the next LW at 0x0 completes normally.
